// File: rtl/cpu_control_unit_pkg.sv
// Shared types for the CPU control unit: opcodes, ALU select codes, FSM states, IR fields.
// STEP_WAIT exists only when CU_SINGLE_STEP_EN is defined.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_ADDI = 4'h6,
    OP_ST   = 4'h8,
    OP_BZ   = 4'h9,
    OP_BP   = 4'hA,
    OP_JMP  = 4'hB,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_WB,
    CLS_ST,
    CLS_BR,
    CLS_JMP,
    CLS_HALT,
    CLS_ILL
  } iclass_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_e;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0011;
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_OR     = 4'b0101;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RS_HI   = 8;
  localparam int RS_LO   = 6;
  localparam int RT_HI   = 5;
  localparam int RT_LO   = 3;
  localparam int IMM9_HI = 8;
  localparam int IMM6_HI = 5;
  localparam int TGT_HI  = 11;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Fetch handshake and datapath control bundle between the control unit and the rest of the core.
interface cpu_control_unit_if #(parameter int PC_WIDTH = 8);
  logic                instr_req;
  logic [PC_WIDTH-1:0] instr_addr;
  logic                instr_valid;
  logic [15:0]         instr_data;
  logic                zero_flag;
  logic                pos_flag;
  logic                rf_write;
  logic [2:0]          rs_addr;
  logic [2:0]          rt_addr;
  logic [2:0]          rd_addr;
  logic [15:0]         imm_data;
  logic                imm_sel;
  logic [3:0]          alu_sel;
  logic                mem_write;

  modport master (
    output instr_req, instr_addr, rf_write, rs_addr, rt_addr, rd_addr,
           imm_data, imm_sel, alu_sel, mem_write,
    input  instr_valid, instr_data, zero_flag, pos_flag
  );

  modport slave (
    input  instr_req, instr_addr, rf_write, rs_addr, rt_addr, rd_addr,
           imm_data, imm_sel, alu_sel, mem_write,
    output instr_valid, instr_data, zero_flag, pos_flag
  );
endinterface

// File: rtl/cpu_control_unit_decoder.sv
// Combinational instruction decoder: IR -> class, register fields, sign-extended immediate,
// ALU controls and illegal-opcode flag.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output iclass_e     class_o,
  output logic [3:0]  op_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rs_o,
  output logic [2:0]  rt_o,
  output logic [15:0] imm_o,
  output logic [3:0]  alu_sel_o,
  output logic        imm_sel_o,
  output logic        illegal_o
);

  logic [15:0] imm9_sx;
  logic [15:0] imm6_sx;

  assign op_o    = ir_i[OP_HI:OP_LO];
  assign rd_o    = ir_i[RD_HI:RD_LO];
  assign rt_o    = ir_i[RT_HI:RT_LO];
  assign imm9_sx = {{7{ir_i[IMM9_HI]}}, ir_i[IMM9_HI:0]};
  assign imm6_sx = {{10{ir_i[IMM6_HI]}}, ir_i[IMM6_HI:0]};

  always_comb begin
    class_o   = CLS_ILL;
    rs_o      = ir_i[RS_HI:RS_LO];
    imm_o     = 16'h0000;
    alu_sel_o = ALU_PASS_A;
    imm_sel_o = 1'b0;
    illegal_o = 1'b0;
    case (op_o)
      OP_NOP:  class_o = CLS_NOP;
      OP_LDI:  begin class_o = CLS_WB; alu_sel_o = ALU_PASS_B; imm_sel_o = 1'b1; imm_o = imm9_sx; end
      OP_ADD:  begin class_o = CLS_WB; alu_sel_o = ALU_ADD; end
      OP_SUB:  begin class_o = CLS_WB; alu_sel_o = ALU_SUB; end
      OP_AND:  begin class_o = CLS_WB; alu_sel_o = ALU_AND; end
      OP_OR:   begin class_o = CLS_WB; alu_sel_o = ALU_OR;  end
      OP_ADDI: begin class_o = CLS_WB; alu_sel_o = ALU_ADD; imm_sel_o = 1'b1; imm_o = imm6_sx; end
      OP_ST:   class_o = CLS_ST;
      // branches test the register held in the rd slot
      OP_BZ, OP_BP: begin class_o = CLS_BR; rs_o = ir_i[RD_HI:RD_LO]; imm_o = imm9_sx; end
      OP_JMP:  class_o = CLS_JMP;
      OP_HALT: class_o = CLS_HALT;
      default: begin class_o = CLS_ILL; illegal_o = 1'b1; end
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle CPU control unit: fetch/decode/execute sequencing, PC update and branching.
// Optional single-step mode (step port, STEP_WAIT state) when CU_SINGLE_STEP_EN is defined.
//
// state       | meaning
// IDLE        | waiting for run
// FETCH       | instr_req high, waiting for instr_valid
// DECODE      | register fields driven, instruction classified
// EXECUTE     | ALU controls driven, flags sampled, branch/jump resolved
// MEMORY      | mem_write pulse (ST)
// WRITEBACK   | rf_write pulse, ALU controls held
// HALT        | stopped until reset
// STEP_WAIT   | single-step only: waiting for step
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
`ifdef CU_SINGLE_STEP_EN
  input  logic step,
`endif
  output logic halted,
  output logic illegal_op,
  cpu_control_unit_if.master bus
);

  state_e              state_q, state_d, eoi_state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         ir_q, ir_d;
  logic                instr_req_q, rf_write_q, mem_write_q, halted_q, illegal_q;
  logic [2:0]          rs_q, rt_q, rd_q;
  logic [15:0]         imm_q;
  logic [3:0]          alu_sel_q;
  logic                imm_sel_q;

  iclass_e     dec_class;
  logic [3:0]  dec_op;
  logic [2:0]  dec_rd, dec_rs, dec_rt;
  logic [15:0] dec_imm;
  logic [3:0]  dec_alu_sel;
  logic        dec_imm_sel, dec_illegal;
  logic        fetch_done, br_taken;

  assign fetch_done = (state_q == S_FETCH) && bus.instr_valid;
  // decoding the incoming word lets the register fields be valid from the first DECODE cycle
  assign ir_d       = fetch_done ? bus.instr_data : ir_q;

  instr_decoder u_dec (
    .ir_i      (ir_d),
    .class_o   (dec_class),
    .op_o      (dec_op),
    .rd_o      (dec_rd),
    .rs_o      (dec_rs),
    .rt_o      (dec_rt),
    .imm_o     (dec_imm),
    .alu_sel_o (dec_alu_sel),
    .imm_sel_o (dec_imm_sel),
    .illegal_o (dec_illegal)
  );

  assign br_taken = ((dec_op == OP_BZ) && bus.zero_flag) ||
                    ((dec_op == OP_BP) && bus.pos_flag);

`ifdef CU_SINGLE_STEP_EN
  assign eoi_state = run ? S_STEP_WAIT : S_IDLE;
`else
  assign eoi_state = run ? S_FETCH : S_IDLE;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (bus.instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        case (dec_class)
          CLS_ILL, CLS_HALT: state_d = S_HALT;
          CLS_NOP:           state_d = eoi_state;
          default:           state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        case (dec_class)
          CLS_ST:  state_d = S_MEMORY;
          CLS_WB:  state_d = S_WRITEBACK;
          default: state_d = eoi_state;
        endcase
      end
      S_MEMORY, S_WRITEBACK: state_d = eoi_state;
      S_HALT:   state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (!run)      state_d = S_IDLE;
        else if (step) state_d = S_FETCH;
      end
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      instr_req_q <= 1'b0;
      rf_write_q  <= 1'b0;
      mem_write_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_sel_q   <= '0;
      imm_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_req_q <= (state_d == S_FETCH);
      rf_write_q  <= (state_d == S_WRITEBACK);
      mem_write_q <= (state_d == S_MEMORY);
      halted_q    <= (state_d == S_HALT);
      if (fetch_done) begin
        ir_q <= bus.instr_data;
        pc_q <= pc_q + PC_WIDTH'(1);
        rs_q <= dec_rs;
        rt_q <= dec_rt;
        rd_q <= dec_rd;
      end
      if ((state_q == S_DECODE) && dec_illegal) illegal_q <= 1'b1;
      if ((state_q == S_DECODE) && (state_d == S_EXECUTE)) begin
        alu_sel_q <= dec_alu_sel;
        imm_sel_q <= dec_imm_sel;
        imm_q     <= dec_imm;
      end
      // pc already points past the branch, so the offset is relative to the next instruction
      if (state_q == S_EXECUTE) begin
        if ((dec_class == CLS_BR) && br_taken) pc_q <= pc_q + PC_WIDTH'(dec_imm);
        else if (dec_class == CLS_JMP)         pc_q <= PC_WIDTH'(ir_q[TGT_HI:0]);
      end
    end
  end

  assign bus.instr_req  = instr_req_q;
  assign bus.instr_addr = pc_q;
  assign bus.rf_write   = rf_write_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.rs_addr    = rs_q;
  assign bus.rt_addr    = rt_q;
  assign bus.rd_addr    = rd_q;
  assign bus.imm_data   = imm_q;
  assign bus.imm_sel    = imm_sel_q;
  assign bus.alu_sel    = alu_sel_q;
  assign halted         = halted_q;
  assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed testbench for cpu_control_unit with a zero-wait instruction memory model.
// With CU_SINGLE_STEP_EN defined only the single-step sequence is exercised.
module tb_cpu_control_unit;

  logic clock = 1'b0;
  logic reset_n;
  logic run;
  logic halted, illegal_op;
  logic mem_en;
`ifdef CU_SINGLE_STEP_EN
  logic step;
`endif
  logic [15:0] imem [256];
  int checks = 0;
  int errors = 0;

  cpu_control_unit_if #(.PC_WIDTH(8)) bus ();

  cpu_control_unit #(.PC_WIDTH(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .run        (run),
`ifdef CU_SINGLE_STEP_EN
    .step       (step),
`endif
    .halted     (halted),
    .illegal_op (illegal_op),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  assign bus.instr_valid = bus.instr_req & mem_en;
  assign bus.instr_data  = imem[bus.instr_addr];

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'h1, rd, imm};
  endfunction

  function automatic logic [15:0] rtype(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[0] = ldi(3'd0, 9'd1);
    imem[1] = ldi(3'd1, 9'd2);
    imem[2] = rtype(4'h2, 3'd2, 3'd0, 3'd1);
    imem[3] = ldi(3'd3, 9'h0FF);
    imem[4] = ldi(3'd3, 9'h1FF);
    imem[5] = {4'h9, 3'd2, 9'h1FD};
    imem[6] = 16'h7000;
    reset_n = 1'b0;
    run     = 1'b0;
    mem_en  = 1'b0;
    bus.zero_flag = 1'b0;
    bus.pos_flag  = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick(1);
    chk("rst_instr_req", 32'(bus.instr_req), 0);
    chk("rst_instr_addr", 32'(bus.instr_addr), 0);
    chk("rst_rf_write", 32'(bus.rf_write), 0);
    chk("rst_mem_write", 32'(bus.mem_write), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal_op), 0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 0);
    chk("rst_imm_data", 32'(bus.imm_data), 0);

`ifdef CU_SINGLE_STEP_EN
    imem[0] = rtype(4'h2, 3'd2, 3'd0, 3'd1);
    imem[1] = rtype(4'h2, 3'd3, 3'd2, 3'd1);
    reset_n = 1'b1;
    run     = 1'b1;
    mem_en  = 1'b1;
    tick(1);
    chk("ss_fetch0_addr", 32'(bus.instr_addr), 0);
    tick(3);
    chk("ss_add_wb", 32'(bus.rf_write), 1);
    tick(1);
    chk("ss_wait_req", 32'(bus.instr_req), 0);
    tick(3);
    chk("ss_wait_req_hold", 32'(bus.instr_req), 0);
    chk("ss_wait_addr", 32'(bus.instr_addr), 1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    chk("ss_fetch1_req", 32'(bus.instr_req), 1);
    chk("ss_fetch1_addr", 32'(bus.instr_addr), 1);
`else
    reset_n = 1'b1;
    run     = 1'b1;
    mem_en  = 1'b1;
    tick(1);
    chk("t1_fetch0_req", 32'(bus.instr_req), 1);
    chk("t1_fetch0_addr", 32'(bus.instr_addr), 0);
    tick(3);
    chk("t1_ldi0_rf_write", 32'(bus.rf_write), 1);
    chk("t1_ldi0_rd", 32'(bus.rd_addr), 0);
    chk("t1_ldi0_imm", 32'(bus.imm_data), 1);
    tick(4);
    chk("t1_ldi1_rf_write", 32'(bus.rf_write), 1);
    chk("t1_ldi1_rd", 32'(bus.rd_addr), 1);
    chk("t1_ldi1_imm", 32'(bus.imm_data), 2);
    tick(4);
    chk("t1_add_rf_write", 32'(bus.rf_write), 1);
    chk("t1_add_rd", 32'(bus.rd_addr), 2);
    chk("t1_add_rs", 32'(bus.rs_addr), 0);
    chk("t1_add_rt", 32'(bus.rt_addr), 1);
    chk("t1_add_alu_sel", 32'(bus.alu_sel), 32'b0010);
    chk("t1_add_imm_sel", 32'(bus.imm_sel), 0);
    chk("t1_add_mem_write", 32'(bus.mem_write), 0);

    tick(1);
    chk("t2_fetch3_addr", 32'(bus.instr_addr), 3);
    chk("t2_fetch3_rf_write", 32'(bus.rf_write), 0);
    tick(2);
    chk("t2_ldi_ff_imm_sel", 32'(bus.imm_sel), 1);
    chk("t2_ldi_ff_alu_sel", 32'(bus.alu_sel), 32'b0001);
    chk("t2_ldi_ff_imm", 32'(bus.imm_data), 32'h00FF);
    chk("t2_ldi_ff_exec_rf_write", 32'(bus.rf_write), 0);
    tick(4);
    chk("t2_ldi_1ff_imm", 32'(bus.imm_data), 32'hFFFF);
    tick(2);
    chk("t3_fetch5_addr", 32'(bus.instr_addr), 5);

    bus.zero_flag = 1'b1;
    tick(1);
    chk("t3_bz_rs", 32'(bus.rs_addr), 2);
    tick(1);
    chk("t3_bz_alu_sel", 32'(bus.alu_sel), 32'b0000);
    tick(1);
    chk("t3_bz_taken_addr", 32'(bus.instr_addr), 3);
    tick(8);
    chk("t3_refetch5_addr", 32'(bus.instr_addr), 5);
    bus.zero_flag = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("t3_bz_rf_write", 32'(bus.rf_write), 0);
    end
    mem_en = 1'b0;
    tick(1);
    chk("t3_bz_not_taken_addr", 32'(bus.instr_addr), 6);

    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t4_stall_req", 32'(bus.instr_req), 1);
      chk("t4_stall_addr", 32'(bus.instr_addr), 6);
      chk("t4_stall_rf_write", 32'(bus.rf_write), 0);
      chk("t4_stall_mem_write", 32'(bus.mem_write), 0);
    end
    mem_en = 1'b1;
    tick(2);
    chk("t4_halted", 32'(halted), 1);
    chk("t4_illegal", 32'(illegal_op), 1);
    chk("t4_halt_req", 32'(bus.instr_req), 0);
    tick(3);
    chk("t4_halt_req_hold", 32'(bus.instr_req), 0);
    chk("t4_halted_hold", 32'(halted), 1);

    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    chk("t5_fetch0_addr", 32'(bus.instr_addr), 0);
    tick(3);
    chk("t5_wb_rf_write", 32'(bus.rf_write), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_rf_write", 32'(bus.rf_write), 0);
    chk("t5_async_pc", 32'(bus.instr_addr), 0);
    chk("t5_async_illegal", 32'(illegal_op), 0);
    chk("t5_async_halted", 32'(halted), 0);

    imem[0]    = {4'hB, 12'h0FF};
    imem[8'hFF] = {4'h8, 3'd0, 3'd5, 3'd6, 3'd0};
    tick(1);
    reset_n = 1'b1;
    tick(1);
    chk("t5_jmp_fetch_addr", 32'(bus.instr_addr), 0);
    tick(3);
    chk("t5_fetch_ff_addr", 32'(bus.instr_addr), 32'hFF);
    chk("t5_fetch_ff_req", 32'(bus.instr_req), 1);
    tick(3);
    chk("t5_st_mem_write", 32'(bus.mem_write), 1);
    chk("t5_st_rf_write", 32'(bus.rf_write), 0);
    chk("t5_st_rs", 32'(bus.rs_addr), 5);
    chk("t5_st_rt", 32'(bus.rt_addr), 6);
    tick(1);
    chk("t5_wrap_addr", 32'(bus.instr_addr), 0);
    chk("t5_wrap_mem_write", 32'(bus.mem_write), 0);
    run = 1'b0;
    tick(3);
    chk("t5_idle_req", 32'(bus.instr_req), 0);
    chk("t5_idle_jmp_done", 32'(bus.instr_addr), 32'hFF);
    tick(2);
    chk("t5_idle_req_hold", 32'(bus.instr_req), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
